// File: rtl/fas_pkg.sv
// Shared definitions for the FFT peak analyzer: sizes, FSM states, bin payload.
// FFT_PEAK_L1_MAG_EN selects the |re|+|im| magnitude (17 bits) instead of re^2+im^2 (33 bits).
package fas_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned NBINS = 16;
    localparam int unsigned WORDW = 2 * DW;
    localparam int unsigned IDXW  = 4;

`ifdef FFT_PEAK_L1_MAG_EN
    localparam int unsigned MAGW = DW + 1;
`else
    localparam int unsigned MAGW = 2 * DW + 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // One FFT bin: real half in the upper word, imaginary half in the lower word.
    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } bin_t;

    // Split a 32-bit bus word into its real/imag halves.
    function automatic bin_t split_bin(input logic [WORDW-1:0] w);
        bin_t b;
        b.re = w[WORDW-1:DW];
        b.im = w[DW-1:0];
        return b;
    endfunction

endpackage

// File: rtl/fft_peak_analyzer_if.sv
// FAS FFT result bus: one frame strobe with 16 bin words, plus the analyzer status.
interface fft_peak_analyzer_if;
    import fas_pkg::*;

    logic             fft_valid;
    logic [WORDW-1:0] fft_d0;
    logic [WORDW-1:0] fft_d1;
    logic [WORDW-1:0] fft_d2;
    logic [WORDW-1:0] fft_d3;
    logic [WORDW-1:0] fft_d4;
    logic [WORDW-1:0] fft_d5;
    logic [WORDW-1:0] fft_d6;
    logic [WORDW-1:0] fft_d7;
    logic [WORDW-1:0] fft_d8;
    logic [WORDW-1:0] fft_d9;
    logic [WORDW-1:0] fft_d10;
    logic [WORDW-1:0] fft_d11;
    logic [WORDW-1:0] fft_d12;
    logic [WORDW-1:0] fft_d13;
    logic [WORDW-1:0] fft_d14;
    logic [WORDW-1:0] fft_d15;
    logic             done;
    logic [IDXW-1:0]  freq;
    logic             busy;
    logic             overflow;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        input  done, freq, busy, overflow
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        output done, freq, busy, overflow
    );

endinterface

// File: rtl/fft_bin_mag.sv
// Combinational magnitude of one FFT bin.
// FFT_PEAK_L1_MAG_EN: |re|+|im| (no multipliers); otherwise re^2+im^2, both exact.
module fft_bin_mag
    import fas_pkg::*;
(
    input  bin_t            bin_in,
    output logic [MAGW-1:0] mag_c
);

`ifdef FFT_PEAK_L1_MAG_EN
    logic signed [DW:0] re_x;
    logic signed [DW:0] im_x;
    logic        [DW:0] re_abs;
    logic        [DW:0] im_abs;

    // Widen by one bit first so that |-32768| = 32768 is representable.
    always_comb begin
        re_x   = {bin_in.re[DW-1], bin_in.re};
        im_x   = {bin_in.im[DW-1], bin_in.im};
        re_abs = re_x[DW] ? -re_x : re_x;
        im_abs = im_x[DW] ? -im_x : im_x;
        mag_c  = re_abs + im_abs;
    end
`else
    logic signed [2*DW-1:0] re_w;
    logic signed [2*DW-1:0] im_w;
    logic signed [2*DW-1:0] re_sq;
    logic signed [2*DW-1:0] im_sq;

    // Squares are non-negative and fit in 2*DW bits; the sum needs one more.
    always_comb begin
        re_w  = {{DW{bin_in.re[DW-1]}}, bin_in.re};
        im_w  = {{DW{bin_in.im[DW-1]}}, bin_in.im};
        re_sq = re_w * re_w;
        im_sq = im_w * im_w;
        mag_c = {1'b0, re_sq} + {1'b0, im_sq};
    end
`endif

endmodule

// File: rtl/fft_peak_analyzer.sv
// Sink of the FAS FFT result bus: captures a 16-bin frame, scans one bin per cycle
// for the largest magnitude and reports its index with a one-cycle done pulse.
// A one-deep pending buffer holds a frame that arrives while a scan is running.
// Optional macro FFT_PEAK_L1_MAG_EN switches the magnitude to |re|+|im|.
module fft_peak_analyzer
    import fas_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fft_peak_analyzer_if.slave bus
);

    typedef logic [NBINS-1:0][WORDW-1:0] frame_t;

    frame_t          in_frame;
    frame_t          act_buf;
    frame_t          pend_buf;

    state_t          state;
    state_t          state_next;
    logic            pend_full;
    logic            pend_full_next;
    logic            ld_act_in;
    logic            ld_act_pend;
    logic            ld_pend_in;
    logic            drop;
    logic            report;

    logic [IDXW-1:0] idx;
    logic [MAGW-1:0] max_mag;
    logic [IDXW-1:0] max_idx;
    bin_t            cur_bin;
    logic [MAGW-1:0] cur_mag_c;

    logic            done_r;
    logic [IDXW-1:0] freq_r;
    logic            busy_r;
    logic            overflow_r;

    // Flatten the bus words into one frame vector, bin 0 in the lowest slot.
    assign in_frame = {bus.fft_d15, bus.fft_d14, bus.fft_d13, bus.fft_d12,
                       bus.fft_d11, bus.fft_d10, bus.fft_d9,  bus.fft_d8,
                       bus.fft_d7,  bus.fft_d6,  bus.fft_d5,  bus.fft_d4,
                       bus.fft_d3,  bus.fft_d2,  bus.fft_d1,  bus.fft_d0};

    // The single magnitude unit sees the bin currently selected from the active buffer.
    assign cur_bin = split_bin(act_buf[idx]);

    fft_bin_mag u_mag (
        .bin_in (cur_bin),
        .mag_c  (cur_mag_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus buffer steering; an IDLE with a pending frame starts it at once.
    always_comb begin
        state_next  = state;
        ld_act_in   = 1'b0;
        ld_act_pend = 1'b0;
        ld_pend_in  = 1'b0;
        drop        = 1'b0;
        report      = 1'b0;

        case (state)
            IDLE: begin
                if (pend_full) begin
                    ld_act_pend = 1'b1;
                    state_next  = SCAN;
                end else if (bus.fft_valid) begin
                    ld_act_in  = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (idx == IDXW'(NBINS - 1)) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                report = 1'b1;
                if (pend_full) begin
                    ld_act_pend = 1'b1;
                    state_next  = SCAN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A frame not taken straight into the active buffer goes to pending if there is room.
        if (bus.fft_valid && !ld_act_in) begin
            if (!pend_full || (state == IDLE)) begin
                ld_pend_in = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        pend_full_next = (pend_full && !ld_act_pend) || ld_pend_in;
    end

    // Scan index, running peak and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_full  <= 1'b0;
            idx        <= '0;
            max_mag    <= '0;
            max_idx    <= '0;
            done_r     <= 1'b0;
            freq_r     <= '0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            pend_full <= pend_full_next;
            idx       <= (state == SCAN) ? idx + IDXW'(1) : '0;

            // Bin 0 seeds the peak; later bins win only when strictly larger.
            if (state == SCAN) begin
                if ((idx == '0) || (cur_mag_c > max_mag)) begin
                    max_mag <= cur_mag_c;
                    max_idx <= idx;
                end
            end

            done_r <= report;
            if (report) begin
                freq_r <= max_idx;
            end
            busy_r     <= (state_next != IDLE) || pend_full_next;
            overflow_r <= overflow_r || drop;
        end
    end

    // Frame storage carries no reset; validity lives in state and pend_full.
    always_ff @(posedge clk) begin
        if (ld_act_in) begin
            act_buf <= in_frame;
        end else if (ld_act_pend) begin
            act_buf <= pend_buf;
        end
        if (ld_pend_in) begin
            pend_buf <= in_frame;
        end
    end

    assign bus.done     = done_r;
    assign bus.freq     = freq_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Self-checking bench for fft_peak_analyzer: directed vector table, multi-cycle
// sequences (pending, overflow, reset mid-scan) and random frames against an argmax model.
module tb_fft_peak_analyzer;

    typedef logic [31:0] frame_t [16];

    typedef struct {
        string      name;
        frame_t     d;
        logic [3:0] exp_freq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_peak_analyzer_if bus();

    fft_peak_analyzer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] drv [16];
    assign bus.fft_d0  = drv[0];
    assign bus.fft_d1  = drv[1];
    assign bus.fft_d2  = drv[2];
    assign bus.fft_d3  = drv[3];
    assign bus.fft_d4  = drv[4];
    assign bus.fft_d5  = drv[5];
    assign bus.fft_d6  = drv[6];
    assign bus.fft_d7  = drv[7];
    assign bus.fft_d8  = drv[8];
    assign bus.fft_d9  = drv[9];
    assign bus.fft_d10 = drv[10];
    assign bus.fft_d11 = drv[11];
    assign bus.fft_d12 = drv[12];
    assign bus.fft_d13 = drv[13];
    assign bus.fft_d14 = drv[14];
    assign bus.fft_d15 = drv[15];

    int         cyc = 0;
    int         done_cyc  [$];
    logic [3:0] done_freq [$];
    logic       done_busy [$];
    int         n_chk  = 0;
    int         n_pass = 0;

    // Number each rising edge and log every done pulse seen just after it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_freq.push_back(bus.freq);
            done_busy.push_back(bus.busy);
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: index of the largest magnitude, lowest index on ties.
    function automatic logic [3:0] ref_peak(input frame_t f);
        longint     best = -1;
        logic [3:0] bi   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(f[k][31:16]));
            longint im = longint'($signed(f[k][15:0]));
            longint m;
`ifdef FFT_PEAK_L1_MAG_EN
            m = (re < 0 ? -re : re) + (im < 0 ? -im : im);
`else
            m = re * re + im * im;
`endif
            if (m > best) begin
                best = m;
                bi   = 4'(k);
            end
        end
        return bi;
    endfunction

    function automatic logic [15:0] small_val();
        case ($urandom_range(0, 2))
            0:       return 16'h0000;
            1:       return 16'h0100;
            default: return 16'hFF00;
        endcase
    endfunction

    function automatic frame_t one_peak(input int k, input logic [31:0] w);
        frame_t f;
        f    = '{default: 32'h0};
        f[k] = w;
        return f;
    endfunction

    // Present a frame for one cycle; returns the edge number that captured it.
    task automatic send_frame(input frame_t f, output int cap);
        @(negedge clk);
        for (int k = 0; k < 16; k++) drv[k] = f[k];
        bus.fft_valid = 1'b1;
        @(posedge clk);
        #1;
        cap           = cyc;
        bus.fft_valid = 1'b0;
        for (int k = 0; k < 16; k++) drv[k] = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_log();
        done_cyc.delete();
        done_freq.delete();
        done_busy.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.fft_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        clear_log();
    endtask

    // Wait (bounded) for the next done pulse and compare its cycle, freq and busy.
    task automatic expect_done(input string nm, input int exp_cyc,
                               input logic [3:0] exp_freq, input logic exp_busy);
        bit         seen;
        int         c;
        logic [3:0] fq;
        logic       bz;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done_cyc.size() > 0) seen = 1'b1;
        end
        chk({nm, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            c  = done_cyc.pop_front();
            fq = done_freq.pop_front();
            bz = done_busy.pop_front();
            chk({nm, " done_cycle"}, 64'(c), 64'(exp_cyc));
            chk({nm, " freq"}, 64'(fq), 64'(exp_freq));
            chk({nm, " busy_at_done"}, 64'(bz), 64'(exp_busy));
        end
    endtask

    vec_t   vecs [7];
    frame_t fa, fb, fc, fr;
    int     cap_a, cap_b, cap_c, gap;

    initial begin
        rst           = 1'b0;
        bus.fft_valid = 1'b0;
        for (int k = 0; k < 16; k++) drv[k] = 32'h0;

        vecs[0].name = "single_bin5";
        vecs[0].d    = one_peak(5, 32'h0300_0400);
        vecs[0].exp_freq = 4'd5;
        vecs[1].name = "tie_3_9";
        vecs[1].d    = one_peak(3, 32'h0100_0000);
        vecs[1].d[9] = 32'h0100_0000;
        vecs[1].exp_freq = 4'd3;
        vecs[2].name = "all_zero";
        vecs[2].d    = '{default: 32'h0};
        vecs[2].exp_freq = 4'd0;
        vecs[3].name = "extremes";
        vecs[3].d    = one_peak(12, 32'h8000_8000);
        vecs[3].d[2] = 32'h7FFF_7FFF;
        vecs[3].exp_freq = 4'd12;
        vecs[4].name = "negative_peak";
        vecs[4].d    = one_peak(7, 32'hFF00_0000);
        vecs[4].d[1] = 32'h0080_0040;
        vecs[4].exp_freq = 4'd7;
        vecs[5].name = "last_bin";
        vecs[5].d    = one_peak(15, 32'h0000_0010);
        vecs[5].d[0] = 32'h0008_0000;
        vecs[5].exp_freq = 4'd15;
        vecs[6].name = "first_bin";
        vecs[6].d    = one_peak(0, 32'h1000_0000);
        vecs[6].d[8] = 32'h0800_0800;
        vecs[6].exp_freq = 4'd0;

        // Reset state.
        idle(3);
        @(negedge clk);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset freq", 64'(bus.freq), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b1;
        clear_log();

        // Directed single frames from the table.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, cap_a);
            @(negedge clk);
            chk({vecs[i].name, " busy_in_scan"}, 64'(bus.busy), 64'd1);
            expect_done(vecs[i].name, cap_a + 17, vecs[i].exp_freq, 1'b0);
            chk({vecs[i].name, " overflow"}, 64'(bus.overflow), 64'd0);
            idle(3);
        end

        // Second frame arriving mid-scan is held in pending and reported 17 cycles later.
        fa = one_peak(4, 32'h0200_0000);
        fb = one_peak(11, 32'h0000_0300);
        fc = one_peak(7, 32'h0500_0000);
        send_frame(fa, cap_a);
        idle(4);
        send_frame(fb, cap_b);
        chk("pending gap", 64'(cap_b - cap_a), 64'd5);
        expect_done("pending A", cap_a + 17, 4'd4, 1'b1);
        expect_done("pending B", cap_a + 34, 4'd11, 1'b0);
        chk("pending overflow", 64'(bus.overflow), 64'd0);
        idle(3);

        // Three frames two cycles apart: the third is dropped and overflow sticks.
        send_frame(fa, cap_a);
        idle(1);
        send_frame(fb, cap_b);
        idle(1);
        send_frame(fc, cap_c);
        chk("overflow gap", 64'(cap_c - cap_a), 64'd4);
        expect_done("overflow A", cap_a + 17, 4'd4, 1'b1);
        expect_done("overflow B", cap_a + 34, 4'd11, 1'b0);
        idle(40);
        chk("overflow no third done", 64'(done_cyc.size()), 64'd0);
        chk("overflow sticky", 64'(bus.overflow), 64'd1);
        chk("overflow freq held", 64'(bus.freq), 64'd11);
        chk("overflow busy idle", 64'(bus.busy), 64'd0);
        apply_reset();
        chk("overflow cleared by reset", 64'(bus.overflow), 64'd0);
        chk("freq cleared by reset", 64'(bus.freq), 64'd0);

        // Reset in the middle of a scan aborts it without a done pulse.
        send_frame(vecs[0].d, cap_a);
        idle(7);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midscan reset edge", 64'(cyc - cap_a), 64'd8);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        idle(30);
        chk("midscan no done", 64'(done_cyc.size()), 64'd0);
        chk("midscan freq", 64'(bus.freq), 64'd0);
        chk("midscan busy", 64'(bus.busy), 64'd0);
        send_frame(vecs[0].d, cap_a);
        expect_done("after midscan", cap_a + 17, 4'd5, 1'b0);
        idle(2);

        // Random isolated frames: wide values and tie-prone small values.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 16; k++) begin
                if (r % 2 == 0) fr[k] = $urandom();
                else            fr[k] = {small_val(), small_val()};
            end
            send_frame(fr, cap_a);
            expect_done($sformatf("rand%0d", r), cap_a + 17, ref_peak(fr), 1'b0);
            idle($urandom_range(0, 3));
        end

        // Random back-to-back pairs with the second frame anywhere inside the first scan.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 16; k++) begin
                fa[k] = $urandom();
                fb[k] = {small_val(), small_val()};
            end
            gap = $urandom_range(1, 16);
            send_frame(fa, cap_a);
            idle(gap - 1);
            send_frame(fb, cap_b);
            chk($sformatf("pair%0d gap", r), 64'(cap_b - cap_a), 64'(gap));
            expect_done($sformatf("pair%0d A", r), cap_a + 17, ref_peak(fa), 1'b1);
            expect_done($sformatf("pair%0d B", r), cap_a + 34, ref_peak(fb), 1'b0);
            chk($sformatf("pair%0d overflow", r), 64'(bus.overflow), 64'd0);
            idle(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_peak_analyzer.md
Name: fft_peak_analyzer

Overview:
- Sink end of the FAS FFT result bus.
- Captures one 16-bin frame (fft_d0..fft_d15) on each fft_valid pulse.
- Scans the bins sequentially to find the bin with the largest magnitude, then reports that bin index on freq with a one-cycle done pulse.
- A one-deep pending buffer absorbs a frame that arrives mid-scan.

Parameters:
- DW, 16, width of each real/imag component (signed two's complement, 8.8 fixed point).
- NBINS, 16, bins per frame. Fixed at 16; freq is 4 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- fft_valid  in  1  one-cycle strobe; fft_d0..fft_d15 valid this cycle.
- fft_d0 .. fft_d15  in  32 each  bin k: [31:16] real, [15:0] imag, signed.
- done  out  1  one-cycle pulse; freq valid this cycle.
- freq  out  4  index of the peak bin of the last completed frame; holds between frames.
- busy  out  1  high while a frame is being scanned or is pending.
- overflow  out  1  sticky; set when a frame is dropped.

Behaviour:
- Reset (rst=0 at a posedge):
  - State goes to IDLE; active and pending buffers are marked empty.
  - done, freq, busy and overflow are all 0.
  - Reset mid-scan aborts the scan with no done pulse.
- Capture: on a posedge with fft_valid=1:
  - IDLE: the frame is written to the active buffer; next state SCAN with bin index 0.
  - Otherwise, pending empty: the frame is written to the pending buffer.
  - Otherwise, pending full: the frame is dropped, overflow is set, and the existing pending frame is kept.
- States:
  - IDLE -> SCAN on capture.
  - SCAN processes one bin per cycle, bins 0..15 in order; after bin 15, next state REPORT.
  - REPORT: done=1 for exactly one cycle and freq is updated.
    - Pending full: pending moves to active (pending goes empty) and next state SCAN with bin 0.
    - Pending empty: next state IDLE.
  - An fft_valid in the REPORT cycle goes to pending if pending is empty, or is dropped if pending is full. It is never lost while pending has room.
- Latency:
  - fft_valid sampled at edge E0; bins scanned at edges E1..E16; done high after E17 (visible cycle 17 after capture).
  - Back-to-back frames through pending: done every 17 cycles.
- Magnitude: mag = re*re + im*im.
  - Each product is a 2*DW-bit signed result, non-negative; the sum is 2*DW+1 = 33 bits unsigned.
  - No truncation.
- Peak tracking:
  - Bin 0 initializes max_mag/max_idx unconditionally.
  - Bins 1..15 replace only if mag > max_mag (strict), so ties resolve to the lowest index.
  - An all-zero frame reports freq=0.
- busy = (state != IDLE) or pending full.
- overflow clears only on reset.
- Frame contents are consumed only from internal buffers; input changes after capture have no effect.

Optional Feature:
- Macro: FFT_PEAK_L1_MAG_EN.
- Defined: mag = |re| + |im|, DW+1 = 17 bits unsigned.
  - |-32768| is taken as 32768 in the widened width; no saturation.
  - Removes both multipliers.
- Undefined: squared magnitude as above.
- Latency, tie rule and all other behaviour are identical either way.

Decomposition:
- Package fas_pkg: DW, NBINS, MAGW (33, or 17 with the macro), state enum {IDLE, SCAN, REPORT}, and a function to split a 32-bit word into real/imag.
- One sub-module, fft_bin_mag: combinational magnitude of one bin, macro-selected. It is instantiated once and fed the bin muxed from the active buffer.

Test Plan:
- Single frame: bin 5 = {0x0300, 0x0400}, all other bins 0 -> done at cycle 17 after fft_valid, freq=5, busy low after done, overflow=0.
- Tie: bins 3 and 9 both {0x0100, 0x0000}, rest 0 -> freq=3; all-zero frame -> freq=0.
- Sign/extremes: bin 12 = {0x8000, 0x8000}, bin 2 = {0x7FFF, 0x7FFF} -> freq=12 in both modes (mag 0x80000000 vs 0x7FFE0002; L1 32768+32768 vs 32767+32767).
- Pending: frame A (peak 4) then frame B (peak 11) 5 cycles later -> done pulses 17 cycles apart, freq 4 then 11, overflow=0.
- Overflow: frames A, B, C at cycles 0, 2, 4 -> freq 4 then 11 for A and B, C dropped, overflow=1 sticky until reset.
- Reset mid-scan: rst=0 at cycle 8 of a scan -> no done pulse, freq=0, busy=0; the next frame is reported normally.
